regfile_sb_bypass: RTL and testbench
====================================

Name: regfile_sb_bypass

Overview:
- Parametrised successor register file for the RISC-V core: NUM_RD read ports, one write port, and write-to-read bypass.
- Adds a per-register busy scoreboard for long-latency producers (loads) and a sequential clear engine that reinitialises the file on request.
- Sits between decode (read and issue) and writeback (write and complete); the debug display port is retained.

Parameters:
- BITS, 32, data width of each register.
- NUM_REGS, 32, register count; power of two, at least 4. AW = $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, 1..4.
- ADDR_WIDTH_DMEM, 10, data-memory byte-address width; sets the stack-pointer reset value.

Ports:
- clk  in  1  clock, rising edge.
- async_reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies [k*AW +: AW].
- rd_data  out  NUM_RD*BITS  read data; port k occupies [k*BITS +: BITS].
- rd_busy  out  NUM_RD  busy flag of the register each port addresses.
- wr_addr  in  AW  write address.
- wr_data  in  BITS  write data.
- reg_en  in  1  write strobe.
- issue_en  in  1  marks issue_addr busy, meaning a producer is in flight.
- issue_addr  in  AW  destination register being issued.
- clear_req  in  1  single-cycle pulse; starts the clear sequence.
- clear_busy  out  1  high while the clear engine runs.
- disp_sel  in  AW  debug display select.
- disp  out  BITS  debug display data, read from storage with no bypass.

Behaviour:
- Reset (async_reset=0):
  - All registers go to 0, except x2 (sp), which goes to 2**ADDR_WIDTH_DMEM - 4.
  - All busy bits go to 0 and the FSM goes to IDLE.
  - clear_busy=0. rd_data and disp reflect the reset contents combinationally.
- x0:
  - Always reads 0 and rd_busy is always 0.
  - Writes to x0 are ignored; issue to x0 is ignored.
- Write: when reg_en=1, wr_addr!=0 and FSM=IDLE, reg[wr_addr] is updated on the rising edge.
- Read is combinational, with zero-cycle bypass:
  - If reg_en=1, wr_addr==rd_addr_k, wr_addr!=0 and FSM=IDLE, then rd_data_k=wr_data.
  - Otherwise rd_data_k=reg[rd_addr_k].
  - All ports are independent; any ports may alias the same address.
- Scoreboard:
  - busy[issue_addr] is set on an edge with issue_en=1 (FSM=IDLE, addr!=0).
  - busy[wr_addr] is cleared on an edge with a valid write.
  - Issue and write to the same register in the same cycle: busy ends 1, because the new producer wins. Data is still written.
  - Issue to one register and write to another in the same cycle: both take effect.
- rd_busy_k: busy[rd_addr_k], forced to 0 when the same-cycle bypass write targets rd_addr_k.
- Clear FSM (states IDLE, CLEAR, DONE):
  - IDLE→CLEAR on clear_req=1. The counter idx loads 1. clear_busy rises on the next edge.
  - CLEAR, each cycle:
    - reg[idx] is set to its reset value and busy[idx] to 0, then idx increments.
    - On idx==NUM_REGS-1 the state goes to DONE.
    - The walk covers NUM_REGS-1 cycles.
  - DONE→IDLE after 1 cycle, with clear_busy=1 in DONE.
  - While not IDLE:
    - reg_en, issue_en and clear_req are ignored and not queued.
    - Reads return stored contents with no bypass.
    - rd_busy reflects the live busy bits.
  - clear_req while already clearing: ignored.
  - Reset asserted mid-clear: immediate full reset, FSM=IDLE.
- Width: idx is AW bits and never wraps past NUM_REGS-1.
- Storage and busy bits are only ever updated from reset values or wr_data; there is no arithmetic.

Decomposition:
- Shared package regfile_pkg:
  - state encoding enum {IDLE, CLEAR, DONE};
  - constant REG_ZERO=0;
  - constant REG_SP=2;
  - function sp_reset_value(ADDR_WIDTH_DMEM).
- One natural sub-module, regfile_read_port: mux, bypass compare and busy lookup for a single port. It is instantiated NUM_RD times in a generate loop.
- The scoreboard and the clear FSM stay in the top module.

Test Plan:
- Reset, then read x0, x2, x5 (default parameters) → rd_data = 0x0, 0x3FC, 0x0; rd_busy=0; clear_busy=0.
- Write x5=0xDEADBEEF while port0 reads x5 and port1 reads x0 in the same cycle → port0=0xDEADBEEF (bypass), port1=0. On the next cycle, with reg_en=0, port0 still reads 0xDEADBEEF.
- issue_en x7 → rd_busy for x7 is 1 from the next cycle. Write x7=0x12 → busy is 0 combinationally in the write cycle (bypass) and stays 0 after the edge. Simultaneous issue x7 plus write x7=0x34 → data 0x34, busy stays 1.
- Attempt to write x0=0xFFFFFFFF and issue x0 → x0 reads 0, rd_busy 0.
- Fill x1..x31 with nonzero values, set busy on x3, then pulse clear_req:
  - clear_busy is high for exactly 32 cycles (31 CLEAR + 1 DONE).
  - A reg_en write of x4=0x55 mid-clear is dropped.
  - Afterwards all registers are 0, sp=0x3FC, all busy bits 0.
- Assert async_reset at clear cycle 10, between clock edges → all outputs return to reset values immediately. After deassertion the FSM is IDLE and clear_busy=0.
- NUM_RD=3 and NUM_REGS=16 build: all three ports read x2 → each returns 0x3FC; widths and slices are correct.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded, bypassed register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;

  // Stack pointer starts one word below the top of data memory.
  function automatic logic [31:0] sp_reset_value(input int unsigned addr_width_dmem);
    return (32'd1 << addr_width_dmem) - 32'd4;
  endfunction

endpackage

// File: rtl/regfile_sb_bypass_if.sv
// Decode/writeback-facing bus of the register file; clock and reset stay outside.
interface regfile_sb_bypass_if #(
  parameter int BITS     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*BITS-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [AW-1:0]          wr_addr;
  logic [BITS-1:0]        wr_data;
  logic                   reg_en;
  logic                   issue_en;
  logic [AW-1:0]          issue_addr;
  logic                   clear_req;
  logic                   clear_busy;
  logic [AW-1:0]          disp_sel;
  logic [BITS-1:0]        disp;

  modport master (
    output rd_addr, wr_addr, wr_data, reg_en, issue_en, issue_addr, clear_req, disp_sel,
    input  rd_data, rd_busy, clear_busy, disp
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, reg_en, issue_en, issue_addr, clear_req, disp_sel,
    output rd_data, rd_busy, clear_busy, disp
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, write bypass and busy lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [AW-1:0]       rd_addr,
  input  logic [BITS-1:0]     regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic                byp_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [BITS-1:0]     wr_data,
  output logic [BITS-1:0]     rd_data,
  output logic                rd_busy
);

  // A same-cycle write both supplies the data and retires the pending producer.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (rd_addr == AW'(REG_ZERO)) begin
      rd_data = {BITS{1'b0}};
      rd_busy = 1'b0;
    end else if (byp_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end else begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_sb_bypass.sv
// Register file with per-register busy scoreboard, write-to-read bypass
// and a sequential clear engine that walks x1..x(N-1) back to reset values.
module regfile_sb_bypass
  import regfile_pkg::*;
#(
  parameter int BITS            = 32,
  parameter int NUM_REGS        = 32,
  parameter int NUM_RD          = 2,
  parameter int ADDR_WIDTH_DMEM = 10
) (
  input logic            clk,
  input logic            async_reset,
  regfile_sb_bypass_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [BITS-1:0] SP_RST = BITS'(sp_reset_value(ADDR_WIDTH_DMEM));

  function automatic logic [BITS-1:0] rst_value(input int unsigned i);
    return (i == REG_SP) ? SP_RST : {BITS{1'b0}};
  endfunction

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                clear_busy_q, clear_busy_d;
  logic [BITS-1:0]     regs_q [NUM_REGS];
  logic [BITS-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic idle_s;
  logic wr_fire_s;
  logic issue_fire_s;

  assign idle_s       = (state_q == IDLE);
  assign wr_fire_s    = idle_s && bus.reg_en   && (bus.wr_addr    != AW'(REG_ZERO));
  assign issue_fire_s = idle_s && bus.issue_en && (bus.issue_addr != AW'(REG_ZERO));

  // Clear sequencer: requests are only honoured from IDLE, so none queue up.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (idx_q == AW'(NUM_REGS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    clear_busy_d = (state_d != IDLE);
  end

  // Storage and scoreboard: a new issue outranks a write to the same register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if ((state_q == CLEAR) && (idx_q == AW'(i))) begin
        regs_d[i] = rst_value(i);
        busy_d[i] = 1'b0;
      end else if (wr_fire_s && (bus.wr_addr == AW'(i))) begin
        regs_d[i] = bus.wr_data;
        busy_d[i] = 1'b0;
      end else begin
        regs_d[i] = regs_q[i];
      end
      if (issue_fire_s && (bus.issue_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
  end

  // All state, including the registered clear_busy flag.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q      <= IDLE;
      idx_q        <= {AW{1'b0}};
      clear_busy_q <= 1'b0;
      busy_q       <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= rst_value(i);
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_busy_q <= clear_busy_d;
      busy_q       <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .BITS     (BITS),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
    ) u_rd (
      .rd_addr (bus.rd_addr[k*AW +: AW]),
      .regs    (regs_q),
      .busy    (busy_q),
      .byp_en  (wr_fire_s),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_data (bus.rd_data[k*BITS +: BITS]),
      .rd_busy (bus.rd_busy[k])
    );
  end

  assign bus.clear_busy = clear_busy_q;
  assign bus.disp       = regs_q[bus.disp_sel];

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Directed bench: reference model plus hand-computed expectations for
// the default build and a 16-register, 3-port build.
module tb_regfile_sb_bypass;

  logic clk = 1'b0;
  logic async_reset = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_bypass_if #(.BITS(32), .NUM_REGS(32), .NUM_RD(2)) ifa ();
  regfile_sb_bypass_if #(.BITS(32), .NUM_REGS(16), .NUM_RD(3)) ifb ();

  regfile_sb_bypass #(.BITS(32), .NUM_REGS(32), .NUM_RD(2), .ADDR_WIDTH_DMEM(10)) dut_a (
    .clk(clk), .async_reset(async_reset), .bus(ifa));
  regfile_sb_bypass #(.BITS(32), .NUM_REGS(16), .NUM_RD(3), .ADDR_WIDTH_DMEM(10)) dut_b (
    .clk(clk), .async_reset(async_reset), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the 32-entry build: contents, busy flags, and
  // how many clock edges of the clear sequence are still to come.
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  int          m_left;

  always @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] <= (i == 2) ? 32'h3FC : 32'h0;
      m_busy <= 32'h0;
      m_left <= 0;
    end else if (m_left > 0) begin
      if (m_left > 1) begin
        m_reg[33 - m_left]  <= ((33 - m_left) == 2) ? 32'h3FC : 32'h0;
        m_busy[33 - m_left] <= 1'b0;
      end
      m_left <= m_left - 1;
    end else begin
      if (ifa.reg_en && (ifa.wr_addr != 5'd0)) begin
        m_reg[ifa.wr_addr]  <= ifa.wr_data;
        m_busy[ifa.wr_addr] <= 1'b0;
      end
      if (ifa.issue_en && (ifa.issue_addr != 5'd0)) m_busy[ifa.issue_addr] <= 1'b1;
      if (ifa.clear_req) m_left <= 32;
    end
  end

  function automatic logic [32:0] exp_port(input logic [4:0] a);
    if (a == 5'd0) return 33'h0;
    if ((m_left == 0) && ifa.reg_en && (ifa.wr_addr == a)) return {1'b0, ifa.wr_data};
    return {m_busy[a], m_reg[a]};
  endfunction

  always @(negedge clk) begin
    logic [32:0] r;
    for (int k = 0; k < 2; k++) begin
      r = exp_port(ifa.rd_addr[k*5 +: 5]);
      chk("model_rd_data", 64'(ifa.rd_data[k*32 +: 32]), 64'(r[31:0]));
      chk("model_rd_busy", 64'(ifa.rd_busy[k]), 64'(r[32]));
    end
    chk("model_clear_busy", 64'(ifa.clear_busy), 64'(m_left > 0));
    chk("model_disp", 64'(ifa.disp), 64'(m_reg[ifa.disp_sel]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  done;
    ifa.rd_addr = 10'd0; ifa.wr_addr = 5'd0; ifa.wr_data = 32'd0; ifa.reg_en = 1'b0;
    ifa.issue_en = 1'b0; ifa.issue_addr = 5'd0; ifa.clear_req = 1'b0; ifa.disp_sel = 5'd0;
    ifb.rd_addr = {4'd2, 4'd2, 4'd2}; ifb.wr_addr = 4'd0; ifb.wr_data = 32'd0; ifb.reg_en = 1'b0;
    ifb.issue_en = 1'b0; ifb.issue_addr = 4'd0; ifb.clear_req = 1'b0; ifb.disp_sel = 4'd0;

    #1 async_reset = 1'b0;
    #21 ifa.rd_addr = {5'd2, 5'd0};
    #1;
    chk("rst_comb_x0", 64'(ifa.rd_data[31:0]), 64'h0);
    chk("rst_comb_sp", 64'(ifa.rd_data[63:32]), 64'h3FC);
    async_reset = 1'b1;

    @(negedge clk);
    chk("rst_x0", 64'(ifa.rd_data[31:0]), 64'h0);
    chk("rst_sp", 64'(ifa.rd_data[63:32]), 64'h3FC);
    chk("rst_busy", 64'(ifa.rd_busy), 64'h0);
    chk("rst_clear_busy", 64'(ifa.clear_busy), 64'h0);
    chk("b_sp_p0", 64'(ifb.rd_data[31:0]), 64'h3FC);
    chk("b_sp_p1", 64'(ifb.rd_data[63:32]), 64'h3FC);
    chk("b_sp_p2", 64'(ifb.rd_data[95:64]), 64'h3FC);
    chk("b_busy", 64'(ifb.rd_busy), 64'h0);
    tick(); ifa.rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("rst_x5", 64'(ifa.rd_data[31:0]), 64'h0);

    // Narrow build: bypass on the top register of port 2.
    tick(); ifb.reg_en = 1'b1; ifb.wr_addr = 4'd15; ifb.wr_data = 32'hCAFE;
    ifb.rd_addr = {4'd15, 4'd2, 4'd2};
    @(negedge clk);
    chk("b_byp_p2", 64'(ifb.rd_data[95:64]), 64'hCAFE);
    chk("b_byp_p0", 64'(ifb.rd_data[31:0]), 64'h3FC);
    tick(); ifb.reg_en = 1'b0;
    @(negedge clk);
    chk("b_stored_p2", 64'(ifb.rd_data[95:64]), 64'hCAFE);

    // Write bypass on x5 while port1 reads x0.
    tick(); ifa.reg_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("byp_x5", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);
    chk("byp_x0", 64'(ifa.rd_data[63:32]), 64'h0);
    tick(); ifa.reg_en = 1'b0;
    @(negedge clk);
    chk("stored_x5", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);

    // Scoreboard on x7.
    tick(); ifa.issue_en = 1'b1; ifa.issue_addr = 5'd7; ifa.rd_addr = {5'd7, 5'd7};
    @(negedge clk);
    chk("issue_same_cycle", 64'(ifa.rd_busy), 64'h0);
    tick(); ifa.issue_en = 1'b0;
    @(negedge clk);
    chk("issue_busy", 64'(ifa.rd_busy), 64'h3);
    tick(); ifa.reg_en = 1'b1; ifa.wr_addr = 5'd7; ifa.wr_data = 32'h12;
    @(negedge clk);
    chk("wb_busy_byp", 64'(ifa.rd_busy), 64'h0);
    chk("wb_data_byp", 64'(ifa.rd_data[31:0]), 64'h12);
    tick(); ifa.reg_en = 1'b0;
    @(negedge clk);
    chk("wb_busy_after", 64'(ifa.rd_busy), 64'h0);
    tick(); ifa.reg_en = 1'b1; ifa.wr_data = 32'h34; ifa.issue_en = 1'b1;
    tick(); ifa.reg_en = 1'b0; ifa.issue_en = 1'b0;
    @(negedge clk);
    chk("iss_wr_data", 64'(ifa.rd_data[63:32]), 64'h34);
    chk("iss_wr_busy", 64'(ifa.rd_busy), 64'h3);

    // x0 is immutable and never busy.
    tick(); ifa.reg_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 32'hFFFFFFFF;
    ifa.issue_en = 1'b1; ifa.issue_addr = 5'd0; ifa.rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("x0_byp", 64'(ifa.rd_data), 64'h0);
    tick(); ifa.reg_en = 1'b0; ifa.issue_en = 1'b0;
    @(negedge clk);
    chk("x0_data", 64'(ifa.rd_data), 64'h0);
    chk("x0_busy", 64'(ifa.rd_busy), 64'h0);
    chk("x0_disp", 64'(ifa.disp), 64'h0);

    // Fill, mark x3 busy, then run a full clear with dropped traffic inside it.
    for (int i = 1; i < 32; i++) begin
      tick(); ifa.reg_en = 1'b1; ifa.wr_addr = 5'(i); ifa.wr_data = 32'h1000_0000 | 32'(i);
    end
    tick(); ifa.reg_en = 1'b0; ifa.issue_en = 1'b1; ifa.issue_addr = 5'd3;
    ifa.rd_addr = {5'd3, 5'd4}; ifa.disp_sel = 5'd31;
    tick(); ifa.issue_en = 1'b0;
    @(negedge clk);
    chk("fill_busy_x3", 64'(ifa.rd_busy[1]), 64'h1);
    chk("fill_x4", 64'(ifa.rd_data[31:0]), 64'h1000_0004);
    chk("fill_disp31", 64'(ifa.disp), 64'h1000_001F);
    tick(); ifa.clear_req = 1'b1;
    @(negedge clk);
    chk("clr_not_yet", 64'(ifa.clear_busy), 64'h0);
    cnt = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      ifa.clear_req = (cnt == 3);
      ifa.reg_en = (cnt == 5); ifa.wr_addr = 5'd4; ifa.wr_data = 32'h55;
      @(negedge clk);
      if (ifa.clear_busy) cnt++;
      else done = 1'b1;
    end
    chk("clr_len", 64'(cnt), 64'd32);
    chk("clr_ended", 64'(done), 64'h1);
    chk("clr_x4_dropped", 64'(ifa.rd_data[31:0]), 64'h0);
    chk("clr_busy_x3", 64'(ifa.rd_busy), 64'h0);
    for (int r = 0; r < 32; r++) begin
      ifa.disp_sel = 5'(r);
      #1 chk("clr_disp", 64'(ifa.disp), (r == 2) ? 64'h3FC : 64'h0);
    end

    // Reset in the middle of a clear.
    tick(); ifa.reg_en = 1'b1; ifa.wr_addr = 5'd31; ifa.wr_data = 32'hBB;
    tick(); ifa.reg_en = 1'b0; ifa.rd_addr = {5'd31, 5'd2}; ifa.disp_sel = 5'd31;
    tick(); ifa.clear_req = 1'b1;
    tick(); ifa.clear_req = 1'b0;
    @(negedge clk);
    chk("mid_pre_x31", 64'(ifa.rd_data[63:32]), 64'hBB);
    repeat (9) @(posedge clk);
    #2 async_reset = 1'b0;
    #1;
    chk("mid_rst_clear_busy", 64'(ifa.clear_busy), 64'h0);
    chk("mid_rst_x31", 64'(ifa.rd_data[63:32]), 64'h0);
    chk("mid_rst_sp", 64'(ifa.rd_data[31:0]), 64'h3FC);
    chk("mid_rst_disp", 64'(ifa.disp), 64'h0);
    #3 async_reset = 1'b1;
    @(negedge clk);
    chk("post_rst_clear_busy", 64'(ifa.clear_busy), 64'h0);
    tick(); ifa.reg_en = 1'b1; ifa.wr_addr = 5'd6; ifa.wr_data = 32'h66; ifa.rd_addr = {5'd6, 5'd6};
    @(negedge clk);
    chk("post_rst_byp", 64'(ifa.rd_data[31:0]), 64'h66);
    tick(); ifa.reg_en = 1'b0;
    @(negedge clk);
    chk("post_rst_stored", 64'(ifa.rd_data[63:32]), 64'h66);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
